// File: rtl/dram_seq.sv
// DRAM access sequencer: turns SAM core word requests into RAS/CAS/WE cycles.
// Optional CAS-before-RAS refresh engine enabled by defining DRAM_REFRESH_EN.
module dram_seq #(
  parameter int T_RCD   = 2,
  parameter int T_CAS   = 2,
  parameter int T_RP    = 2,
  parameter int REF_INT = 880
) (
  input  logic        OSCOut,
  input  logic        RES,
  input  logic [21:0] Z,
  input  logic        nWEi,
  input  logic        Req,
  output logic        Ack,
  output logic        Done,
  output logic        Busy,
  output logic [10:0] MA,
  output logic        nRAS,
  output logic        nCAS,
  output logic        nWE
);

  // state  | meaning
  // IDLE   | strobes high, MA held; refresh pending beats Req
  // ROW    | row address driven, nRAS low (T_RCD cycles)
  // COL    | column address driven, nRAS/nCAS low, nWE = latched we (T_CAS)
  // PRE    | precharge, all strobes high (T_RP cycles)
  // RCAS   | refresh: nCAS low ahead of nRAS (1 cycle)
  // RRAS   | refresh: nCAS and nRAS low (T_RCD+T_CAS cycles)
  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_PRE, S_RCAS, S_RRAS
  } state_t;

  if (T_RCD < 1 || T_RCD > 15) begin : g_bad_t_rcd
    $error("T_RCD out of range 1..15");
  end
  if (T_CAS < 1 || T_CAS > 15) begin : g_bad_t_cas
    $error("T_CAS out of range 1..15");
  end
  if (T_RP < 1 || T_RP > 15) begin : g_bad_t_rp
    $error("T_RP out of range 1..15");
  end
  if (REF_INT < 2 || REF_INT > 65535) begin : g_bad_ref_int
    $error("REF_INT out of range 2..65535");
  end

  // Phase counter is one bit wider than a single interval so RRAS (T_RCD+T_CAS) fits.
  localparam logic [4:0] LD_RCD  = 5'(T_RCD - 1);
  localparam logic [4:0] LD_CAS  = 5'(T_CAS - 1);
  localparam logic [4:0] LD_RP   = 5'(T_RP - 1);
  localparam logic [4:0] LD_RRAS = 5'(T_RCD + T_CAS - 1);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic        w_tc;
  logic [10:0] r_row, r_col;
  logic        r_we;
  logic        w_ref_due;
  logic        w_latch;
  logic        w_ack, w_done, w_nras, w_ncas, w_nwe;
  logic [10:0] w_ma;

`ifdef DRAM_REFRESH_EN
  logic [15:0] r_timer;
  logic        r_pending;
  logic        w_expire;
  logic        w_enter_rcas;

  // An expiry coinciding with the IDLE decision is serviced at once.
  assign w_expire     = (r_timer == 16'd0);
  assign w_ref_due    = r_pending | w_expire;
  assign w_enter_rcas = (r_state == S_IDLE) && w_ref_due;

  always_ff @(posedge OSCOut) begin
    if (RES) begin
      r_timer   <= 16'(REF_INT - 1);
      r_pending <= 1'b0;
    end else begin
      r_timer <= w_expire ? 16'(REF_INT - 1) : r_timer - 16'd1;
      if (w_enter_rcas)
        r_pending <= 1'b0;
      else if (w_expire)
        r_pending <= 1'b1;
    end
  end
`else
  assign w_ref_due = 1'b0;
`endif

  assign w_tc = (r_cnt == 5'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_tc ? r_cnt : r_cnt - 5'd1;
    w_latch     = 1'b0;
    w_ack       = 1'b0;
    w_done      = 1'b0;
    w_nras      = 1'b1;
    w_ncas      = 1'b1;
    w_nwe       = 1'b1;
    w_ma        = MA;
    case (r_state)
      S_IDLE: begin
        if (w_ref_due) begin
          w_state_nxt = S_RCAS;
          w_cnt_nxt   = 5'd0;
        end else if (Req) begin
          w_ack       = 1'b1;
          w_latch     = 1'b1;
          w_state_nxt = S_ROW;
          w_cnt_nxt   = LD_RCD;
        end
      end
      S_ROW: begin
        w_nras = 1'b0;
        w_ma   = r_row;
        if (w_tc) begin
          w_state_nxt = S_COL;
          w_cnt_nxt   = LD_CAS;
        end
      end
      S_COL: begin
        w_nras = 1'b0;
        w_ncas = 1'b0;
        w_nwe  = r_we;
        w_ma   = r_col;
        if (w_tc) begin
          w_done      = 1'b1;
          w_state_nxt = S_PRE;
          w_cnt_nxt   = LD_RP;
        end
      end
      S_PRE: begin
        if (w_tc)
          w_state_nxt = S_IDLE;
      end
      S_RCAS: begin
        w_ncas      = 1'b0;
        w_state_nxt = S_RRAS;
        w_cnt_nxt   = LD_RRAS;
      end
      S_RRAS: begin
        w_nras = 1'b0;
        w_ncas = 1'b0;
        if (w_tc) begin
          w_state_nxt = S_PRE;
          w_cnt_nxt   = LD_RP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered images of the current state, hence one cycle behind it.
  always_ff @(posedge OSCOut) begin
    if (RES) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_row   <= 11'd0;
      r_col   <= 11'd0;
      r_we    <= 1'b1;
      Ack     <= 1'b0;
      Done    <= 1'b0;
      Busy    <= 1'b0;
      MA      <= 11'd0;
      nRAS    <= 1'b1;
      nCAS    <= 1'b1;
      nWE     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_row <= Z[10:0];
        r_col <= Z[21:11];
        r_we  <= nWEi;
      end
      Ack  <= w_ack;
      Done <= w_done;
      Busy <= (r_state != S_IDLE);
      MA   <= w_ma;
      nRAS <= w_nras;
      nCAS <= w_ncas;
      nWE  <= w_nwe;
    end
  end

endmodule

// File: tb/tb_dram_seq.sv
// Self-checking bench for dram_seq: scoreboard of accepted accesses checked per cycle after Ack.
// Refresh-specific checks follow DRAM_REFRESH_EN in the same way as the design.
module tb_dram_seq;

  localparam int T_RCD   = 2;
  localparam int T_CAS   = 2;
  localparam int T_RP    = 2;
  localparam int REF_INT = 20;
  localparam int T_TOT   = 1 + T_RCD + T_CAS + T_RP;

  logic        OSCOut = 1'b0;
  logic        RES    = 1'b1;
  logic [21:0] Z      = 22'd0;
  logic        nWEi   = 1'b1;
  logic        Req    = 1'b0;
  logic        Ack, Done, Busy, nRAS, nCAS, nWE;
  logic [10:0] MA;

  dram_seq #(.T_RCD(T_RCD), .T_CAS(T_CAS), .T_RP(T_RP), .REF_INT(REF_INT)) dut (
    .OSCOut(OSCOut), .RES(RES), .Z(Z), .nWEi(nWEi), .Req(Req),
    .Ack(Ack), .Done(Done), .Busy(Busy), .MA(MA),
    .nRAS(nRAS), .nCAS(nCAS), .nWE(nWE)
  );

  always #5 OSCOut = ~OSCOut;

  int cyc = 0;
  always @(posedge OSCOut) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;
  int n_ack   = 0;

  typedef struct {
    logic [10:0] row;
    logic [10:0] col;
    logic        we;
  } acc_t;

  acc_t sb[$];
  acc_t cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic acc_t mk(input logic [21:0] z, input logic w);
    acc_t a;
    a.row = z[10:0];
    a.col = z[21:11];
    a.we  = w;
    return a;
  endfunction

  // Per-cycle monitor: each Ack pops one expected access and checks the next T_TOT cycles.
  logic        mon_active = 1'b0;
  int          mon_rel    = 0;
  logic        e_nras, e_ncas, e_nwe, e_done, e_busy;
  logic [10:0] e_ma;

  always @(negedge OSCOut) begin
    if (RES) begin
      mon_active = 1'b0;
      sb.delete();
    end else begin
      if (mon_active) begin
        mon_rel++;
        e_nras = !(mon_rel >= 1 && mon_rel <= T_RCD + T_CAS);
        e_ncas = !(mon_rel > T_RCD && mon_rel <= T_RCD + T_CAS);
        e_nwe  = e_ncas | cur.we;
        e_done = (mon_rel == T_RCD + T_CAS);
        e_busy = (mon_rel < T_TOT);
        e_ma   = (mon_rel <= T_RCD) ? cur.row : cur.col;
        check($sformatf("acc_rel%0d", mon_rel), {nRAS, nCAS, nWE, Done, Busy, MA},
              {e_nras, e_ncas, e_nwe, e_done, e_busy, e_ma});
        if (mon_rel < T_TOT) check($sformatf("ack_pulse_rel%0d", mon_rel), Ack, 0);
        if (mon_rel == T_TOT) mon_active = 1'b0;
      end
      if (Ack) begin
        n_ack++;
        check("ack_has_req", sb.size() > 0, 1);
        check("ack_busy", Busy, 0);
        if (sb.size() > 0) begin
          cur        = sb.pop_front();
          mon_active = 1'b1;
          mon_rel    = 0;
        end
      end
    end
  end

  task automatic wait_ack(output int c);
    logic got = 1'b0;
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge OSCOut);
      if (Ack) begin
        got = 1'b1;
        c   = cyc;
        break;
      end
    end
    check("ack_seen", got, 1);
  endtask

  task automatic do_acc(input logic [21:0] z, input logic w);
    int rc, c;
    sb.push_back(mk(z, w));
    @(posedge OSCOut); #1;
    Z = z; nWEi = w; Req = 1'b1; rc = cyc;
    wait_ack(c);
`ifndef DRAM_REFRESH_EN
    check("ack_lat", c - rc, 1);
`endif
    @(posedge OSCOut); #1;
    Req = 1'b0; Z = ~z; nWEi = ~w;
    repeat (T_TOT) @(posedge OSCOut);
  endtask

  task automatic check_reset(input string tag);
    check(tag, {nRAS, nCAS, nWE, Ack, Done, Busy, MA}, {3'b111, 3'b000, 11'h000});
  endtask

`ifdef DRAM_REFRESH_EN
  task automatic find_fall(output int f);
    logic prev = nCAS;
    logic got  = 1'b0;
    f = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge OSCOut);
      if (!nCAS && prev) begin
        got = 1'b1;
        f   = cyc;
        break;
      end
      prev = nCAS;
    end
    check("cbr_seen", got, 1);
  endtask

  task automatic refresh_tests;
    int f1, f2, f3, c;
    find_fall(f1);
    check("cbr_rcas", {nRAS, nCAS, nWE}, 3'b101);
    for (int j = 1; j <= T_RCD + T_CAS + T_RP; j++) begin
      @(negedge OSCOut);
      check($sformatf("cbr_rel%0d", j), {nRAS, nCAS, nWE, Ack, Done},
            (j <= T_RCD + T_CAS) ? 5'b00100 : 5'b11100);
    end
    find_fall(f2);
    check("cbr_period", f2 - f1, REF_INT);
    f3 = f2 + REF_INT;
    // Req becomes visible in the same IDLE cycle the timer expires.
    for (int i = 0; i < 60 && cyc < f3 - 2; i++) begin
      @(posedge OSCOut); #1;
    end
    sb.push_back(mk(22'h1234AB, 1'b1));
    Z = 22'h1234AB; nWEi = 1'b1; Req = 1'b1;
    wait_ack(c);
    check("cbr_ack_after", c, f3 + T_TOT);
    @(posedge OSCOut); #1;
    Req = 1'b0;
    repeat (T_TOT) @(posedge OSCOut);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, n0, ncas_low;
    logic [21:0] za, zb;

    repeat (3) @(posedge OSCOut);
    @(negedge OSCOut);
    check_reset("rst_init");
    @(posedge OSCOut); #1;
    RES = 1'b0;

`ifdef DRAM_REFRESH_EN
    refresh_tests();
`endif

    do_acc(22'h2AB155, 1'b1);
    do_acc(22'h2AB155, 1'b0);

    // Back-to-back: Req held high across two accesses, Z switched after the first Ack.
    za = 22'h0F0F0F; zb = 22'h3C3C3C;
    sb.push_back(mk(za, 1'b1));
    sb.push_back(mk(zb, 1'b0));
    @(posedge OSCOut); #1;
    Z = za; nWEi = 1'b1; Req = 1'b1;
    wait_ack(c1);
    @(posedge OSCOut); #1;
    Z = zb; nWEi = 1'b0;
    wait_ack(c2);
`ifdef DRAM_REFRESH_EN
    check("b2b_gap_min", (c2 - c1) >= T_TOT, 1);
`else
    check("b2b_gap", c2 - c1, T_TOT);
`endif
    @(posedge OSCOut); #1;
    Req = 1'b0; Z = 22'h3FFFFF; nWEi = 1'b1;
    repeat (T_TOT) @(posedge OSCOut);

    // Req raised while busy and dropped before IDLE must not start an access.
    sb.push_back(mk(22'h155AAA, 1'b1));
    @(posedge OSCOut); #1;
    Z = 22'h155AAA; nWEi = 1'b1; Req = 1'b1;
    wait_ack(c1);
    @(posedge OSCOut); #1;
    Req = 1'b0;
    @(posedge OSCOut); #1;
    Req = 1'b1;
    @(posedge OSCOut); #1;
    Req = 1'b0;
    n0 = n_ack;
    repeat (12) @(posedge OSCOut);
    check("drop_no_ack", n_ack - n0, 0);

    for (int k = 0; k < 4; k++) begin
      do_acc(22'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset asserted during ROW.
    sb.push_back(mk(22'h2AB155, 1'b0));
    @(posedge OSCOut); #1;
    Z = 22'h2AB155; nWEi = 1'b0; Req = 1'b1;
    wait_ack(c1);
    @(posedge OSCOut); #1;
    RES = 1'b1; Req = 1'b0;
    @(posedge OSCOut);
    @(negedge OSCOut);
    check_reset("rst_mid_row");
    @(posedge OSCOut);
    @(posedge OSCOut); #1;
    RES = 1'b0;
    @(posedge OSCOut);
    @(negedge OSCOut);
    check_reset("rst_release");

`ifndef DRAM_REFRESH_EN
    ncas_low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge OSCOut);
      if (!nCAS) ncas_low++;
    end
    check("no_refresh", ncas_low, 0);
`endif

    repeat (4) @(posedge OSCOut);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
